// File: rtl/minibus_pkg.sv
// Shared minibus types: request/response packets, arbiter state encoding and
// a helper that tells whether a request packet carries a read or write.
package minibus_pkg;

   localparam int unsigned MINIBUS_MAX_MASTERS = 8;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        ren;
      logic        wen;
   } minibus_req_pack;

   typedef struct packed {
      logic [31:0] rdata;
      logic        ready;
      logic        error;
   } minibus_res_pack;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

   function automatic logic req_active(minibus_req_pack r);
      return r.ren | r.wen;
   endfunction

endpackage

// File: rtl/minibus_rr_picker.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per requester
//   ptr     : index of the last winner; search starts at ptr+1 and wraps
//   pick    : index of the first active requester found
//   any_req : at least one request bit is set (pick is 0 otherwise)
module minibus_rr_picker #(
   parameter int unsigned REQ_COUNT = 2,
   parameter int unsigned IDX_W     = $clog2(REQ_COUNT)
) (
   input  logic [REQ_COUNT-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [IDX_W-1:0]     pick,
   output logic                 any_req
);

   always_comb begin
      int unsigned idx;
      pick    = '0;
      any_req = 1'b0;
      idx     = 0;
      // Offset k=REQ_COUNT lands back on ptr itself, so the last winner is
      // considered only after everyone else.
      for (int unsigned k = 1; k <= REQ_COUNT; k++) begin
         idx = (32'(ptr) + k) % REQ_COUNT;
         if (!any_req && req[idx]) begin
            pick    = IDX_W'(idx);
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/minibus_arbiter.sv
// Round-robin arbiter sharing one minibus master port among MASTER_COUNT
// requesters, with a registered grant and a watchdog that forces an error
// response when the slave stalls.
//   clk, rst    : clock, asynchronous active-high reset
//   m_req/m_res : per-master request in / response out
//   bus_req     : request forwarded to the decoder
//   bus_res     : response from the decoder
//   grant       : one-hot owner, zero when idle
//   busy        : a transaction is in flight
//   timeout_err : one-cycle pulse when the watchdog fires
module minibus_arbiter
   import minibus_pkg::*;
#(
   parameter int unsigned MASTER_COUNT   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  minibus_req_pack         m_req [MASTER_COUNT],
   output minibus_res_pack         m_res [MASTER_COUNT],
   output minibus_req_pack         bus_req,
   input  minibus_res_pack         bus_res,
   output logic [MASTER_COUNT-1:0] grant,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int unsigned IDX_W   = $clog2(MASTER_COUNT);
   // Keep the counter at least one bit wide when the watchdog is disabled.
   localparam int unsigned WD_W    = (CNT_W < 1) ? 1 : CNT_W;
   localparam int unsigned WD_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);

   arb_state_e              state_q, state_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [WD_W-1:0]         wdog_q, wdog_d;
   logic [MASTER_COUNT-1:0] active;
   logic [IDX_W-1:0]        pick;
   logic                    any_req;

   always_comb begin
      for (int i = 0; i < MASTER_COUNT; i++) begin
         active[i] = req_active(m_req[i]);
      end
   end

   minibus_rr_picker #(
      .REQ_COUNT (MASTER_COUNT),
      .IDX_W     (IDX_W)
   ) u_picker (
      .req     (active),
      .ptr     (rr_ptr_q),
      .pick    (pick),
      .any_req (any_req)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= IDX_W'(MASTER_COUNT - 1);
         wdog_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         wdog_q   <= wdog_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      wdog_d      = wdog_q;
      bus_req     = '0;
      grant       = '0;
      busy        = 1'b0;
      timeout_err = 1'b0;
      for (int i = 0; i < MASTER_COUNT; i++) begin
         m_res[i] = '0;
      end

      unique case (state_q)
         ARB_IDLE: begin
            if (any_req) begin
               owner_d  = pick;
               rr_ptr_d = pick;
               wdog_d   = '0;
               state_d  = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            busy           = 1'b1;
            grant[owner_q] = 1'b1;
            bus_req        = m_req[owner_q];
            m_res[owner_q] = bus_res;
            // Priority: completion, then abort, then watchdog.
            if (bus_res.ready) begin
               state_d = ARB_IDLE;
            end else if (!active[owner_q]) begin
               state_d = ARB_IDLE;
            end else if (WD_EN && (wdog_q == WD_W'(WD_LAST))) begin
               bus_req              = '0;
               m_res[owner_q]       = '0;
               m_res[owner_q].ready = 1'b1;
               m_res[owner_q].error = 1'b1;
               timeout_err          = 1'b1;
               state_d              = ARB_IDLE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_minibus_arbiter.sv
// Scoreboarded bench for minibus_arbiter with three masters and a 4-cycle
// watchdog. Stimulus pushes expected responses; a negedge monitor pops one
// whenever any master sees ready and also checks the bus invariants.
module tb_minibus_arbiter;
   import minibus_pkg::*;

   localparam int unsigned NM = 3;
   localparam logic [31:0] KEY = 32'h5A5A_0000;

   logic                   clk;
   logic                   rst;
   minibus_req_pack        m_req [NM];
   minibus_res_pack        m_res [NM];
   minibus_req_pack        bus_req;
   minibus_res_pack        bus_res;
   logic [NM-1:0]          grant;
   logic                   busy;
   logic                   timeout_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          master;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   // Slave model: answers slave_lat cycles into BUSY with rdata = addr ^ KEY.
   int slave_lat = 0;
   int slave_cnt;

   minibus_arbiter #(
      .MASTER_COUNT   (NM),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .m_req       (m_req),
      .m_res       (m_res),
      .bus_req     (bus_req),
      .bus_res     (bus_res),
      .grant       (grant),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) slave_cnt <= 0;
      else if (!busy || bus_res.ready) slave_cnt <= 0;
      else slave_cnt <= slave_cnt + 1;
   end

   always_comb begin
      bus_res = '0;
      if (busy && slave_cnt == slave_lat) begin
         bus_res.ready = 1'b1;
         for (int i = 0; i < NM; i++) begin
            if (grant[i]) bus_res.rdata = m_req[i].addr ^ KEY;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int m, input logic [31:0] addr, input logic err);
      exp_t e;
      e.master = m;
      e.rdata  = err ? 32'h0 : (addr ^ KEY);
      e.err    = err;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int m, input logic rd, input logic [31:0] addr);
      m_req[m].addr  = addr;
      m_req[m].wdata = addr + 32'h1;
      m_req[m].ren   = rd;
      m_req[m].wen   = ~rd;
   endtask

   // Monitor: scoreboard pop on ready plus per-cycle invariants.
   always @(negedge clk) begin
      if (!rst) begin
         check("grant_onehot0", 32'($onehot0(grant)), 1);
         if (!busy) check("idle_bus_req_zero", 32'(bus_req != '0), 0);
         for (int i = 0; i < NM; i++) begin
            if (m_res[i].ready) begin
               check("ready_only_owner", 32'(grant[i]), 1);
               if (sb.size() == 0) begin
                  check("unexpected_ready", 1, 0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("sb_master", i, e.master);
                  check("sb_rdata", m_res[i].rdata, e.rdata);
                  check("sb_error", 32'(m_res[i].error), 32'(e.err));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      rst = 1'b1;
      for (int i = 0; i < NM; i++) m_req[i] = '0;

      // Reset values
      #12;
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_bus_req", 32'(bus_req != '0), 0);
      for (int i = 0; i < NM; i++) check("rst_m_res", 32'(m_res[i] != '0), 0);
      @(negedge clk);
      rst = 1'b0;

      // Single master, slave ready after 3 wait cycles
      slave_lat = 3;
      step();
      set_req(0, 1'b1, 32'h100);
      push(0, 32'h100, 1'b0);
      @(negedge clk);
      check("t1_latency_grant", grant, 0);
      check("t1_latency_busy", busy, 0);
      step();
      n = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) check("t1_grant", grant, 3'b001);
         check("t1_m1_quiet", 32'(m_res[1].ready), 0);
         if (m_res[0].ready) begin
            n = c;
            break;
         end
         step();
      end
      check("t1_ready_cycle", n, 4);
      step();
      m_req[0] = '0;
      @(negedge clk);
      check("t1_idle_busy", busy, 0);

      // Contention between masters 0 and 1, 1-cycle slave; rr_ptr is 0 here
      slave_lat = 0;
      for (int k = 0; k < 100; k++) begin
         if (k % 2 == 0) push(1, 32'h300, 1'b0);
         else push(0, 32'h200, 1'b0);
      end
      step();
      set_req(0, 1'b1, 32'h200);
      set_req(1, 1'b1, 32'h300);
      @(negedge clk);
      for (int k = 0; k < 100; k++) begin
         step();
         @(negedge clk);
         check("t2_grant", grant, (k % 2 == 0) ? 3'b010 : 3'b001);
         step();
         if (k == 99) begin
            m_req[0] = '0;
            m_req[1] = '0;
         end
         @(negedge clk);
         check("t2_idle_gap", busy, 0);
      end

      // Move rr_ptr to 1, then masters 0 and 2 compete: 2 wins first
      step();
      set_req(1, 1'b1, 32'h400);
      push(1, 32'h400, 1'b0);
      step();
      @(negedge clk);
      check("t3_grant_m1", grant, 3'b010);
      step();
      m_req[1] = '0;
      set_req(0, 1'b1, 32'h500);
      set_req(2, 1'b0, 32'h600);
      push(2, 32'h600, 1'b0);
      push(0, 32'h500, 1'b0);
      step();
      @(negedge clk);
      check("t3_grant_m2_first", grant, 3'b100);
      step();
      m_req[2] = '0;
      @(negedge clk);
      check("t3_idle", busy, 0);
      step();
      @(negedge clk);
      check("t3_grant_m0_second", grant, 3'b001);
      step();
      m_req[0] = '0;
      @(negedge clk);

      // Watchdog: slave never answers, error forced on BUSY cycle 4
      slave_lat = 1000;
      step();
      set_req(0, 1'b0, 32'h700);
      push(0, 32'h700, 1'b1);
      step();
      n = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (m_res[0].ready) begin
            n = c;
            check("t4_timeout_err", timeout_err, 1);
            check("t4_bus_req_zero", 32'(bus_req != '0), 0);
            break;
         end
         check("t4_no_early_err", timeout_err, 0);
         step();
      end
      check("t4_fire_cycle", n, 4);
      step();
      m_req[0] = '0;
      @(negedge clk);
      check("t4_idle_after", busy, 0);
      check("t4_single_pulse", timeout_err, 0);

      // Abort: master 1 owns, drops its request in BUSY cycle 2; master 0 follows
      step();
      set_req(0, 1'b1, 32'h800);
      set_req(1, 1'b1, 32'h900);
      push(0, 32'h800, 1'b0);
      step();
      @(negedge clk);
      check("t5_grant_m1", grant, 3'b010);
      step();
      m_req[1] = '0;
      @(negedge clk);
      check("t5_abort_no_ready", 32'(m_res[1].ready), 0);
      check("t5_abort_no_err", timeout_err, 0);
      step();
      slave_lat = 1;
      @(negedge clk);
      check("t5_idle_after_abort", busy, 0);
      step();
      @(negedge clk);
      check("t5_grant_m0", grant, 3'b001);
      step();
      @(negedge clk);
      step();
      m_req[0] = '0;
      @(negedge clk);
      check("t5_idle_end", busy, 0);

      // Asynchronous reset in the middle of a BUSY cycle
      slave_lat = 1000;
      step();
      set_req(1, 1'b1, 32'hB00);
      step();
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_grant", grant, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_bus_req", 32'(bus_req != '0), 0);
      set_req(0, 1'b1, 32'hA00);
      slave_lat = 0;
      push(0, 32'hA00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step();
      @(negedge clk);
      check("t6_m0_first", grant, 3'b001);
      step();
      m_req[0] = '0;
      m_req[1] = '0;
      @(negedge clk);
      check("t6_idle_end", busy, 0);

      step();
      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/minibus_arbiter.md
Name: minibus_arbiter

Overview:
- Shares one minibus master port (the request side of minibus_decoder) between MASTER_COUNT requesters, such as the instruction fetch, data and debug units.
- Uses round-robin arbitration with a registered grant.
- The granted master holds the bus until the transaction completes, the master aborts, or a watchdog timeout fires.
- On timeout the arbiter returns an error response in place of the slave.

Parameters:
MASTER_COUNT, 2, number of requesting masters (legal range 2..8)
TIMEOUT_CYCLES, 64, BUSY cycles without bus_res.ready before an error response is forced; 0 disables the watchdog
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter (derived, do not override)

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
m_req  in  minibus_req_pack [MASTER_COUNT]  per-master request packet
m_res  out  minibus_res_pack [MASTER_COUNT]  per-master response packet
bus_req  out  minibus_req_pack  request driven to the decoder's master interface
bus_res  in  minibus_res_pack  response from the decoder's master interface
grant  out  MASTER_COUNT  one-hot current owner; all zero when idle
busy  out  1  high in BUSY
timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Request detection: a master is active when m_req[i].ren | m_req[i].wen.
- State machine (arb_state_e): IDLE and BUSY.
- Reset values:
  - state=IDLE, owner=0, rr_ptr=MASTER_COUNT-1 (so master 0 wins first), wdog=0.
  - Outputs: grant=0, busy=0, timeout_err=0, bus_req='0, every m_res='0.
- IDLE:
  - bus_req='0, so the decoder sees no ren/wen.
  - All m_res are '0 (ready=0).
  - If any master is active, the picker selects the first active index searching from rr_ptr+1, wrapping modulo MASTER_COUNT.
  - On the next edge: owner<=pick, rr_ptr<=pick, state<=BUSY, wdog<=0.
  - Arbitration latency is exactly one cycle from request to grant.
- BUSY:
  - bus_req = m_req[owner]; grant = one-hot(owner); m_res[owner] = bus_res; every other m_res is '0.
  - Completion: bus_res.ready=1 → state<=IDLE. The owner sees ready in that same cycle.
  - Back-to-back transactions always pass through one IDLE cycle. This cycle is where fairness is enforced.
  - Abort: owner not active (ren=wen=0) → state<=IDLE next edge, no response is generated. Abort takes priority over timeout; completion takes priority over abort.
  - Watchdog:
    - wdog increments each BUSY cycle without ready.
    - When TIMEOUT_CYCLES≠0 and wdog==TIMEOUT_CYCLES-1 without ready, that cycle forces m_res[owner] to ready=1, error=1, rdata='0.
    - bus_req is forced to '0 in that cycle, timeout_err=1, and state<=IDLE.
  - The owner's request changing address or data mid-BUSY is passed through unchanged. Masters must hold the request stable until ready.
- Fairness: a master continuously requesting waits at most MASTER_COUNT-1 transactions.
- Reset mid-operation: returns immediately to reset values. A pending slave response is discarded.
- Invariants:
  - grant is one-hot or zero.
  - Only the owner ever receives ready=1.
  - bus_req is never non-zero in IDLE.

Decomposition:
- minibus_pkg gains:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e
  - function automatic logic req_active(minibus_req_pack)
  - localparam MINIBUS_MAX_MASTERS=8
- Sub-module minibus_rr_picker: purely combinational.
  - Inputs: req vector [MASTER_COUNT], ptr.
  - Outputs: pick index, any_req.
  - Reused later by the DMA channel scheduler.

Test Plan:
- Single master: master 0 reads addr 0x100, slave ready after 3 cycles.
  - Expected: grant=01 one cycle after request; m_res[0].ready on the 4th BUSY cycle; master 1 sees ready=0 throughout.
- Contention: masters 0 and 1 both request continuously with 1-cycle slaves.
  - Expected: grant sequence 01,10,01,10 with one IDLE cycle between grants; no starvation over 100 transactions.
- Three masters, rr_ptr=1, masters 0 and 2 active.
  - Expected: master 2 is granted first, then master 0.
- Timeout with TIMEOUT_CYCLES=4 and the slave never asserting ready.
  - Expected: on the 4th BUSY cycle m_res[owner] has ready=1, error=1, bus_req='0 and timeout_err pulses once; next cycle is IDLE.
- Abort: owner drops ren in the 2nd BUSY cycle.
  - Expected: IDLE next cycle, no ready or error delivered, and another pending master is granted on the following edge.
- Asynchronous reset asserted mid-BUSY between clock edges.
  - Expected: grant, busy and bus_req go to 0 immediately; after release, master 0 wins first.
